// File: rtl/freq_gate_ctrl.sv
// Gate-window controller and result latch for the equal-precision frequency
// counter. Opens the counter gate (clk_en) for a programmable number of
// clk_100M cycles, waits for the counter's is_count gate to close, lets the
// counter outputs settle, then captures both counts and raises a sticky done.
module freq_gate_ctrl #(
  parameter int unsigned GATE_DEFAULT   = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 200000000,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] gate_len,
  input  logic        clr_done,
  input  logic        is_count,
  input  logic [31:0] base_count,
  input  logic [31:0] test_count,
  output logic        clk_en,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] base_latched,
  output logic [31:0] test_latched
);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DRAIN,
    SETTLE
  } state_t;

  localparam logic [31:0] GATE_LOAD    = 32'(GATE_DEFAULT - 1);
  localparam logic [31:0] TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] SETTLE_LOAD  = 32'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        seen_rise, seen_nxt;
  logic        done_nxt, timeout_nxt;
  logic        capture;
  logic        s1, s2, s3;
  logic        rise, fall;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Bring the test-domain gate into clk_100M and keep one extra stage for edges.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= is_count;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Control state, shared down-counter, sticky flags and capture registers.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      seen_rise    <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      base_latched <= '0;
      test_latched <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      seen_rise <= seen_nxt;
      done      <= done_nxt;
      timeout   <= timeout_nxt;
      if (capture) begin
        base_latched <= base_count;
        test_latched <= test_count;
      end
    end
  end

  // Next-state, counter and flag logic; a set event overrides clr_done.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    seen_nxt    = seen_rise;
    done_nxt    = done;
    timeout_nxt = timeout;
    capture     = 1'b0;
    clk_en      = 1'b0;
    busy        = (state != IDLE);

    if (clr_done) begin
      done_nxt    = 1'b0;
      timeout_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt     = (gate_len == '0) ? GATE_LOAD : (gate_len - 32'd1);
          seen_nxt    = 1'b0;
          done_nxt    = 1'b0;
          timeout_nxt = 1'b0;
          state_nxt   = GATE;
        end
      end
      GATE: begin
        clk_en = 1'b1;
        if (rise) seen_nxt = 1'b1;
        if (cnt == '0) begin
          cnt_nxt   = TIMEOUT_LOAD;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      DRAIN: begin
        if (rise) seen_nxt = 1'b1;
        // A fall without a prior rise belongs to a gate opened before start.
        if (fall && seen_rise) begin
          cnt_nxt   = SETTLE_LOAD;
          state_nxt = SETTLE;
        end else if (cnt == '0) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: a small equal-precision counter model drives
// is_count/base_count/test_count; expected gate lengths and measurement
// results are queued as stimulus is issued and checked by separate monitors.
module tb_freq_gate_ctrl;

  localparam int unsigned GATE_DEF = 500;
  localparam int unsigned TO_CYC   = 2000;
  localparam int unsigned SETTLE   = 4;

  logic        clk_100M = 1'b0;
  logic        clk_test = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic [31:0] gate_len = '0;
  logic        clr_done = 1'b0;
  logic        is_count = 1'b0;
  logic [31:0] base_count = '0;
  logic [31:0] test_count = '0;
  logic        clk_en, busy, done, timeout;
  logic [31:0] base_latched, test_latched;

  logic        dead = 1'b0;
  int unsigned cur_gate = 0;
  int unsigned cyc = 0;
  int unsigned bcnt_run = 0;
  int unsigned tcnt_run = 0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_to;
    logic [31:0] base;
    logic [31:0] test;
    int unsigned cyc;
    int unsigned gate;
  } meas_t;

  meas_t       meas_q[$];
  int unsigned gate_q[$];

  freq_gate_ctrl #(
    .GATE_DEFAULT  (GATE_DEF),
    .TIMEOUT_CYCLES(TO_CYC),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk_100M    (clk_100M),
    .rst_n       (rst_n),
    .start       (start),
    .gate_len    (gate_len),
    .clr_done    (clr_done),
    .is_count    (is_count),
    .base_count  (base_count),
    .test_count  (test_count),
    .clk_en      (clk_en),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .base_latched(base_latched),
    .test_latched(test_latched)
  );

  // 100 MHz base clock; 1 MHz test clock offset so edges never coincide.
  initial forever #5 clk_100M = ~clk_100M;
  initial begin
    #3;
    forever #500 clk_test = ~clk_test;
  end

  // Counter model: base count runs while the gate is open.
  always @(posedge clk_100M) begin
    cyc      <= cyc + 1;
    bcnt_run <= is_count ? bcnt_run + 1 : 0;
  end

  // Counter model: gate opens/closes on test clock edges, results update on close.
  always @(posedge clk_test) begin
    if (is_count) begin
      if (!clk_en) begin
        is_count   <= 1'b0;
        base_count <= bcnt_run;
        test_count <= tcnt_run + 1;
        meas_q.push_back('{1'b0, bcnt_run, tcnt_run + 1, cyc, cur_gate});
      end else begin
        tcnt_run <= tcnt_run + 1;
      end
    end else if (clk_en && !dead) begin
      is_count <= 1'b1;
      tcnt_run <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int unsigned act,
                           input int unsigned lo, input int unsigned hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Gate monitor: length of each clk_en pulse against the queued length.
  int unsigned run = 0;
  always @(negedge clk_100M) begin
    if (!rst_n) begin
      run = 0;
    end else if (clk_en) begin
      run++;
    end else if (run != 0) begin
      if (gate_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL gate_unexpected actual=%0d required=none", run);
      end else begin
        chk("gate_cycles", run, gate_q.pop_front());
      end
      run = 0;
    end
  end

  // Result monitor: each done/timeout rise against the queued expectation.
  logic        done_q = 1'b0, to_q = 1'b0;
  logic [31:0] prev_base = '0, prev_test = '0;
  meas_t       m;
  always @(negedge clk_100M) begin
    if (!rst_n) begin
      prev_base = '0;
      prev_test = '0;
      done_q    = 1'b0;
      to_q      = 1'b0;
    end else begin
      if ((done && !done_q) || (timeout && !to_q)) begin
        if (meas_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL result_unexpected actual=done%0b/timeout%0b required=none", done, timeout);
        end else begin
          m = meas_q.pop_front();
          chk("result_kind_timeout", {31'd0, timeout && !to_q}, {31'd0, m.is_to});
          if (m.is_to) begin
            chk("to_base_kept", base_latched, prev_base);
            chk("to_test_kept", test_latched, prev_test);
            chk("to_done", {31'd0, done}, 32'd0);
            chk("to_busy", {31'd0, busy}, 32'd0);
          end else begin
            chk("base_latched", base_latched, m.base);
            chk("test_latched", test_latched, m.test);
            chk_range("test_nominal", test_latched, m.gate / 100 - 1, m.gate / 100 + 1);
            chk_range("done_latency", cyc - m.cyc, SETTLE + 2, SETTLE + 4);
            prev_base = m.base;
            prev_test = m.test;
          end
        end
      end
      done_q = done;
      to_q   = timeout;
    end
  end

  task automatic do_start(input logic [31:0] g);
    @(negedge clk_100M);
    start    = 1'b1;
    gate_len = g;
    @(negedge clk_100M);
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (busy && n < budget) begin
      @(negedge clk_100M);
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk_100M);
  endtask

  initial begin
    int unsigned n;
    // Reset and idle behaviour.
    repeat (3) @(negedge clk_100M);
    chk("rst_clk_en", {31'd0, clk_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_base", base_latched, 32'd0);
    chk("rst_test", test_latched, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_100M);
    clr_done = 1'b1;
    @(negedge clk_100M);
    clr_done = 1'b0;
    @(negedge clk_100M);
    chk("idle_clr_done", {31'd0, done}, 32'd0);
    chk("idle_clr_busy", {31'd0, busy}, 32'd0);
    chk("idle_clr_clk_en", {31'd0, clk_en}, 32'd0);

    // Nominal 1000-cycle measurement.
    cur_gate = 1000;
    gate_q.push_back(1000);
    do_start(32'd1000);
    chk("nom_busy", {31'd0, busy}, 32'd1);
    chk("nom_clk_en", {31'd0, clk_en}, 32'd1);
    wait_idle("nom_idle", 1000 + TO_CYC + 50);
    chk("nom_done", {31'd0, done}, 32'd1);
    chk("nom_timeout", {31'd0, timeout}, 32'd0);

    // Restart attempt mid-gate, then clr_done held across the capture edge.
    gate_q.push_back(1000);
    do_start(32'd1000);
    chk("start_clears_done", {31'd0, done}, 32'd0);
    repeat (200) @(negedge clk_100M);
    start    = 1'b1;
    gate_len = 32'd50;
    @(negedge clk_100M);
    start    = 1'b0;
    n = 0;
    while (clk_en && n < 1200) begin
      @(negedge clk_100M);
      n++;
    end
    chk("gate_closed", {31'd0, clk_en}, 32'd0);
    clr_done = 1'b1;
    n = 0;
    while (!done && n < TO_CYC + 50) begin
      @(negedge clk_100M);
      n++;
    end
    clr_done = 1'b0;
    chk("collision_done_seen", {31'd0, done}, 32'd1);
    @(negedge clk_100M);
    chk("collision_set_wins", {31'd0, done}, 32'd1);
    wait_idle("collision_idle", 50);
    clr_done = 1'b1;
    @(negedge clk_100M);
    clr_done = 1'b0;
    @(negedge clk_100M);
    chk("clr_done_clears", {31'd0, done}, 32'd0);

    // Default length via gate_len == 0.
    cur_gate = GATE_DEF;
    gate_q.push_back(GATE_DEF);
    do_start(32'd0);
    wait_idle("default_idle", GATE_DEF + TO_CYC + 50);
    chk("default_done", {31'd0, done}, 32'd1);

    // Dead input: gate never opens at the counter, drain times out.
    dead = 1'b1;
    gate_q.push_back(100);
    meas_q.push_back('{1'b1, '0, '0, 0, 0});
    do_start(32'd100);
    wait_idle("dead_idle", 100 + TO_CYC + 50);
    chk("dead_timeout", {31'd0, timeout}, 32'd1);
    chk("dead_done", {31'd0, done}, 32'd0);

    // Shortest gate: one cycle; counter held dead so the result is a timeout.
    gate_q.push_back(1);
    meas_q.push_back('{1'b1, '0, '0, 0, 0});
    do_start(32'd1);
    wait_idle("gate1_idle", 1 + TO_CYC + 50);
    chk("gate1_timeout", {31'd0, timeout}, 32'd1);
    dead = 1'b0;

    // Reset mid-gate aborts at once; a fresh start gives a full gate.
    do_start(32'd1000);
    chk("start_clears_timeout", {31'd0, timeout}, 32'd0);
    repeat (300) @(posedge clk_100M);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_clk_en", {31'd0, clk_en}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk_100M);
    rst_n = 1'b1;
    @(negedge clk_100M);
    chk("midrst_base", base_latched, 32'd0);
    chk("midrst_test", test_latched, 32'd0);
    repeat (150) @(negedge clk_100M);
    meas_q.delete();
    cur_gate = 1000;
    gate_q.push_back(1000);
    do_start(32'd1000);
    wait_idle("postrst_idle", 1000 + TO_CYC + 50);
    chk("postrst_done", {31'd0, done}, 32'd1);

    repeat (5) @(negedge clk_100M);
    chk("gate_q_drained", gate_q.size(), 32'd0);
    chk("meas_q_drained", meas_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
Gate-window controller and result latch for the equal-precision frequency counter. Runs in the clk_100M domain and drives the counter's clk_en gate for a programmable number of cycles. It then waits for the counter's is_count gate to close and captures the 32-bit base and test counts into stable holding registers. Finally it raises a sticky done flag, which feeds the interrupt/register-select path.

Parameters:
GATE_DEFAULT, 100000000, gate length in clk_100M cycles used when gate_len==0 (1 s)
TIMEOUT_CYCLES, 200000000, max cycles in DRAIN waiting for is_count to fall
SETTLE_CYCLES, 4, cycles between detected is_count fall and capture (counter outputs update on async negedge)

Ports:
clk_100M  in  1  system clock, 100 MHz
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle request to begin a measurement; ignored unless IDLE
gate_len  in  32  gate length in cycles, sampled on accepted start; 0 selects GATE_DEFAULT
clr_done  in  1  single-cycle clear of done and timeout
is_count  in  1  counter gate, asynchronous to clk_100M (test-clock domain)
base_count  in  32  counter base-clock result
test_count  in  32  counter test-clock result
clk_en  out  1  gate request to counter
busy  out  1  high in any state except IDLE
done  out  1  sticky, set on successful capture
timeout  out  1  sticky, set on failed measurement
base_latched  out  32  captured base_count
test_latched  out  32  captured test_count

Behaviour:
- Reset (async, rst_n low): state=IDLE. clk_en, busy, done and timeout are 0. base_latched=0, test_latched=0. Synchronizer flops are 0. Reset mid-measurement aborts immediately, with clk_en low in the same instant.
- is_count is passed through a 2-FF synchronizer (s1,s2) plus a third flop s3. Rise = s2&~s3. Fall = ~s2&s3.
- States: IDLE, GATE, DRAIN, SETTLE.
- IDLE: on start, load cnt = (gate_len==0 ? GATE_DEFAULT : gate_len)-1, clear seen_rise, go to GATE. Also clear done and timeout in the same cycle.
- GATE: clk_en=1. Any synced rise sets seen_rise. Each cycle cnt decrements. When cnt==0, go to DRAIN with cnt=TIMEOUT_CYCLES-1. clk_en is high for exactly N cycles, where N is the effective gate length.
- DRAIN: clk_en=0.
  - Fall with seen_rise=1: go to SETTLE with cnt=SETTLE_CYCLES-1.
  - Fall with seen_rise=0: ignore it. This is a stale gate from before start.
  - Rise in DRAIN: sets seen_rise.
  - cnt reaching 0 with no qualifying fall: set timeout and return to IDLE. Latches are unchanged.
- SETTLE: count down. At cnt==0, latch base_latched<=base_count and test_latched<=test_count, set done, return to IDLE. The latch and the done rise happen on the same edge.
- Latency: done rises SETTLE_CYCLES+3 ±1 cycles after the is_count falling edge.
- start while busy: ignored. gate_len is not resampled.
- clr_done clears done and timeout.
  - Same cycle as a set event: the set wins.
  - Same cycle as an accepted start: both flags end up 0.
- The cnt width is 32 bits. No wrap occurs because loads are always ≥0 after the -1, given gate_len≥1 or the default. gate_len=1 gives a 1-cycle gate.
- Latches change only on capture. They remain readable while busy.

Test Plan:
- Reset/idle: rst_n low, then high. All outputs are 0. Pulsing clr_done changes nothing.
- Nominal: gate_len=1000, start. Test clock 1 MHz in a counter model, base 100 MHz. clk_en is high exactly 1000 cycles. done rises within SETTLE_CYCLES+4 cycles of the is_count fall. test_latched=10±1, base_latched matches the model's value exactly.
- Default length: gate_len=0, GATE_DEFAULT overridden to 500. clk_en is high exactly 500 cycles.
- Dead input: is_count held 0, TIMEOUT_CYCLES=2000, gate_len=100. After 100+2000 cycles, timeout=1, done=0, busy=0, latches keep their prior values.
- Start while busy plus clr/set collision: pulse start again mid-GATE, and observe no restart (total gate = first length). Assert clr_done on the exact capture cycle, and done ends at 1.
- Reset mid-gate: drop rst_n 300 cycles into a 1000-cycle gate. clk_en goes 0 asynchronously and the state is IDLE. A new start gives a full 1000-cycle gate.
